// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one-entry holding buffer per functional unit, one registered broadcast per cycle.
// Build option CDB_RR_EN selects round-robin grant; without it, fixed priority load > mult > add.
module cdb_arbiter #(
    parameter int W = 40
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         add_valid,
    input  logic [W-1:0] add_data,
    output logic         add_ready,
    input  logic         mul_valid,
    input  logic [W-1:0] mul_data,
    output logic         mul_ready,
    input  logic         ld_valid,
    input  logic [W-1:0] ld_data,
    output logic         ld_ready,
    output logic         cdb_valid,
    output logic [W-1:0] cdb_bus,
    output logic [1:0]   cdb_src,
    output logic         drop_err
);
    localparam int N = 3;

    logic [N-1:0] in_valid;
    logic [W-1:0] in_data [N];
    logic [N-1:0] ready;
    logic [N-1:0] xfer;
    logic [N-1:0] keep;
    logic [N-1:0] gnt;
    logic [1:0]   gnt_idx;
    logic         gnt_any;

    logic [N-1:0] buf_v_q, buf_v_d;
    logic [W-1:0] buf_data_q [N];
    logic         cdb_valid_q, cdb_valid_d;
    logic [W-1:0] cdb_bus_q, cdb_bus_d;
    logic [1:0]   cdb_src_q, cdb_src_d;
    logic         drop_err_q, drop_err_d;

    assign in_valid   = {ld_valid, mul_valid, add_valid};
    assign in_data[0] = add_data;
    assign in_data[1] = mul_data;
    assign in_data[2] = ld_data;

    // A freed-this-cycle buffer may be refilled in the same cycle.
    assign ready = ~buf_v_q | gnt;
    assign xfer  = in_valid & ready;

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_src
            // Tag 8'h00 marks an idle word; it is accepted but never buffered.
            assign keep[gi] = xfer[gi] & (in_data[gi][W-1:W-8] != 8'h00);

            always_ff @(posedge clk) begin
                if (keep[gi]) begin
                    buf_data_q[gi] <= in_data[gi];
                end
            end
        end
    endgenerate

`ifdef CDB_RR_EN
    logic [1:0] last_q, last_d;

    always_comb begin
        int unsigned idx;
        gnt     = '0;
        gnt_idx = 2'd0;
        gnt_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(last_q) + 1 + k) % N;
            if (!gnt_any && buf_v_q[idx]) begin
                gnt_any   = 1'b1;
                gnt[idx]  = 1'b1;
                gnt_idx   = idx[1:0];
            end
        end
        last_d = gnt_any ? gnt_idx : last_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 2'd2;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        gnt     = '0;
        gnt_idx = 2'd0;
        gnt_any = |buf_v_q;
        if (buf_v_q[2]) begin
            gnt[2]  = 1'b1;
            gnt_idx = 2'd2;
        end else if (buf_v_q[1]) begin
            gnt[1]  = 1'b1;
            gnt_idx = 2'd1;
        end else if (buf_v_q[0]) begin
            gnt[0]  = 1'b1;
            gnt_idx = 2'd0;
        end
    end
`endif

    always_comb begin
        buf_v_d     = (buf_v_q & ~gnt) | keep;
        drop_err_d  = |(xfer & ~keep);
        cdb_valid_d = gnt_any;
        cdb_src_d   = gnt_any ? gnt_idx : 2'd3;
        cdb_bus_d   = '0;
        if (gnt_any) begin
            case (gnt_idx)
                2'd1:    cdb_bus_d = buf_data_q[1];
                2'd2:    cdb_bus_d = buf_data_q[2];
                default: cdb_bus_d = buf_data_q[0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_v_q     <= '0;
            cdb_valid_q <= 1'b0;
            cdb_bus_q   <= '0;
            cdb_src_q   <= 2'd3;
            drop_err_q  <= 1'b0;
        end else begin
            buf_v_q     <= buf_v_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_bus_q   <= cdb_bus_d;
            cdb_src_q   <= cdb_src_d;
            drop_err_q  <= drop_err_d;
        end
    end

    assign add_ready = ready[0];
    assign mul_ready = ready[1];
    assign ld_ready  = ready[2];
    assign cdb_valid = cdb_valid_q;
    assign cdb_bus   = cdb_bus_q;
    assign cdb_src   = cdb_src_q;
    assign drop_err  = drop_err_q;
endmodule
